// File: rtl/serial_shift_ctrl_pkg.sv
// serial_shift_ctrl_pkg: shared FSM state type and default word width
package serial_shift_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;
    localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/serial_shift_ctrl_bit_counter.sv
// shift_bit_counter: counts shifted bits, saturating at WIDTH-1 so it never wraps
// Ports: Clk, Rst (async high), Clr (sync clear), En (count), Tc (count==WIDTH-1)
module shift_bit_counter
    import serial_shift_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Clr,
    input  logic En,
    output logic Tc
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    logic [CW-1:0] count;
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) count <= '0;
        else if (Clr) count <= '0;
        else if (En && !Tc) count <= count + CW'(1);
    assign Tc = count == LAST;
endmodule

// File: rtl/serial_shift_ctrl.sv
// serial_shift_ctrl: full-duplex serial shifter with IDLE/SHIFT/DONE control
// Ports: Clk, Rst (async high), Start/Din (accept in IDLE), SerIn (rx bit),
//        Ready (IDLE), ShiftEn (SHIFT), SerOut (tx bit), Dout (last rx word), Done (1-cycle)
module serial_shift_ctrl
    import serial_shift_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] Din,
    input  logic             SerIn,
    output logic             Ready,
    output logic             ShiftEn,
    output logic             SerOut,
    output logic [WIDTH-1:0] Dout,
    output logic             Done
);
    state_t state;
    logic [WIDTH-1:0] shifter, shifted;
    logic armed, accept, tc;
    // armed stays low through the first edge after reset release so Start is ignored there
    assign accept  = state == IDLE && Start && armed;
    assign shifted = MSB_FIRST ? {shifter[WIDTH-2:0], SerIn} : {SerIn, shifter[WIDTH-1:1]};
    assign SerOut  = ShiftEn & (MSB_FIRST ? shifter[WIDTH-1] : shifter[0]);
    shift_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .Clk(Clk),
        .Rst(Rst),
        .Clr(accept),
        .En (state == SHIFT),
        .Tc (tc)
    );
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            state   <= IDLE;
            shifter <= '0;
            Dout    <= '0;
            armed   <= 1'b0;
            Ready   <= 1'b1;
            ShiftEn <= 1'b0;
            Done    <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: if (accept) begin
                    shifter <= Din;
                    state   <= SHIFT;
                    Ready   <= 1'b0;
                    ShiftEn <= 1'b1;
                end
                SHIFT: begin
                    shifter <= shifted;
                    if (tc) begin
                        Dout    <= shifted;
                        state   <= DONE;
                        ShiftEn <= 1'b0;
                        Done    <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                    Ready <= 1'b1;
                end
            endcase
        end
endmodule

// File: tb/tb_serial_shift_ctrl.sv
// tb_serial_shift_ctrl: randomized self-checking bench for MSB-first and LSB-first instances
module tb_serial_shift_ctrl;
    logic clk, rst, start, loop, rnd_m, rnd_l;
    logic [7:0] din;
    logic ready_m, shift_en_m, ser_out_m, done_m, ser_in_m;
    logic ready_l, shift_en_l, ser_out_l, done_l, ser_in_l;
    logic [7:0] dout_m, dout_l;
    int checks = 0, failures = 0;

    assign ser_in_m = loop ? ser_out_m : rnd_m;
    assign ser_in_l = loop ? ser_out_l : rnd_l;

    serial_shift_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .Clk(clk), .Rst(rst), .Start(start), .Din(din), .SerIn(ser_in_m),
        .Ready(ready_m), .ShiftEn(shift_en_m), .SerOut(ser_out_m), .Dout(dout_m), .Done(done_m)
    );
    serial_shift_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .Clk(clk), .Rst(rst), .Start(start), .Din(din), .SerIn(ser_in_l),
        .Ready(ready_l), .ShiftEn(shift_en_l), .SerOut(ser_out_l), .Dout(dout_l), .Done(done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_ready_m"}, ready_m, 1);
        chk({tag, "_ready_l"}, ready_l, 1);
        chk({tag, "_shift_en"}, {shift_en_m, shift_en_l}, 0);
        chk({tag, "_ser_out"}, {ser_out_m, ser_out_l}, 0);
        chk({tag, "_done"}, {done_m, done_l}, 0);
    endtask

    // mode: 0 loopback, 1 random SerIn, 2 SerIn tied 1, 3 SerIn tied 0
    task automatic xfer(input logic [7:0] d, input int mode, input bit poke);
        logic [7:0] em, el;
        logic sm, sl;
        em = 0;
        el = 0;
        loop = mode == 0;
        start = 1;
        din = d;
        @(negedge clk);
        start = 0;
        din = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            chk("shift_ready", {ready_m, ready_l}, 0);
            chk("shift_en", {shift_en_m, shift_en_l}, 2'b11);
            chk("shift_done", {done_m, done_l}, 0);
            chk("ser_out_m", ser_out_m, d[7-i]);
            chk("ser_out_l", ser_out_l, d[i]);
            sm = mode == 0 ? d[7-i] : mode == 1 ? 1'($urandom) : mode == 2;
            sl = mode == 0 ? d[i] : mode == 1 ? 1'($urandom) : mode == 2;
            rnd_m = sm;
            rnd_l = sl;
            em[7-i] = sm;
            el[i] = sl;
            @(negedge clk);
        end
        chk("done_pulse", {done_m, done_l}, 2'b11);
        chk("done_shift_en", {shift_en_m, shift_en_l}, 0);
        chk("done_ready", {ready_m, ready_l}, 0);
        chk("done_ser_out", {ser_out_m, ser_out_l}, 0);
        chk("dout_m", dout_m, em);
        chk("dout_l", dout_l, el);
        if (poke) start = 1;
        @(negedge clk);
        start = 0;
        idle_chk("after_done");
        chk("dout_m_hold", dout_m, em);
        chk("dout_l_hold", dout_l, el);
        if (poke) begin
            @(negedge clk);
            idle_chk("poke_ignored");
        end
    endtask

    initial begin
        int dones;
        rst = 1; start = 0; din = 0; loop = 0; rnd_m = 0; rnd_l = 0;
        repeat (2) @(negedge clk);
        idle_chk("reset");
        chk("reset_dout", {dout_m, dout_l}, 0);
        rst = 0;
        @(negedge clk);
        xfer(8'hA5, 0, 0);
        xfer(8'h00, 2, 0);
        chk("tie1_dout_ff", {dout_m, dout_l}, 16'hFFFF);
        xfer(8'h01, 0, 0);
        xfer(8'h3C, 1, 1);
        for (int n = 0; n < 10; n++) xfer(8'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        // Start held high: accepts every 10 cycles
        dones = 0;
        loop = 0;
        start = 1;
        din = 8'($urandom);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            rnd_m = 1'($urandom);
            rnd_l = 1'($urandom);
            chk("held_shift_en", shift_en_m, (c % 10 >= 1) && (c % 10 <= 8));
            chk("held_done", done_m, c % 10 == 9);
            chk("held_ready", ready_m, c % 10 == 0);
            if (done_m) dones++;
            if (c == 30) start = 0;
        end
        chk("held_done_count", dones, 3);
        xfer(8'h5A, 3, 0);
        chk("tie0_dout", {dout_m, dout_l}, 0);
        // reset during SHIFT after three bits
        loop = 0; rnd_m = 1; rnd_l = 1;
        start = 1;
        din = 8'hC3;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        chk("pre_reset_shift", {shift_en_m, shift_en_l}, 2'b11);
        rst = 1;
        start = 1;
        #1;
        idle_chk("async_reset");
        chk("async_reset_dout", {dout_m, dout_l}, 0);
        @(negedge clk);
        idle_chk("reset_held");
        rst = 0;
        @(negedge clk);
        idle_chk("release_edge");
        start = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("abort_no_done", {done_m, done_l}, 0);
        end
        idle_chk("abort_idle");
        chk("abort_dout", {dout_m, dout_l}, 0);
        xfer(8'h96, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_shift_ctrl.md
SERIAL_SHIFT_CTRL -- requirements
Module: serial_shift_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: word length in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = MSB shifted out first, 0 = LSB first.
REQ-003 Clk  in  1: the single clock; all state changes on its rising edge.
REQ-004 Rst  in  1: reset, asynchronous and active-high.
REQ-005 Start  in  1: request to transfer Din; accepted only when Ready=1.
REQ-006 Din  in  WIDTH: parallel word to transmit, sampled on the accept edge.
REQ-007 SerIn  in  1: serial receive bit, sampled on every rising edge in SHIFT.
REQ-008 Ready  out  1: high only in IDLE.
REQ-009 ShiftEn  out  1: high only in SHIFT; qualifies SerOut for the downstream shift register.
REQ-010 SerOut  out  1: current transmit bit; 0 outside SHIFT.
REQ-011 Dout  out  WIDTH: last fully received word.
REQ-012 Done  out  1: one-cycle pulse marking transfer completion.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 IDLE: Start=1 at an edge SHALL load the shifter with Din, clear the bit count and enter SHIFT.
REQ-015 SHIFT: SerOut SHALL equal shifter[WIDTH-1] when MSB_FIRST=1, else shifter[0].
REQ-016 Each SHIFT edge SHALL shift the shifter by one position toward the output end, insert SerIn at the vacated end and increment the count.
REQ-017 The SHIFT edge with count==WIDTH-1 SHALL enter DONE and load Dout with the shifted result that includes that final SerIn bit.
REQ-018 DONE SHALL last exactly one cycle with Done=1, then return to IDLE unconditionally.
REQ-019 Start in SHIFT or DONE SHALL be ignored; there is no queuing.
REQ-020 Latency: Start accepted at edge k gives ShiftEn high for cycles k+1..k+WIDTH and Done high in cycle k+WIDTH+1.
REQ-021 Throughput with Start held high SHALL be one word per WIDTH+2 cycles.
REQ-022 Dout SHALL change only on entry to DONE and SHALL hold its value otherwise.
REQ-023 Ready, ShiftEn, SerOut and Done SHALL be decoded from registered state only, never from Start.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH)) bits wide, SHALL not wrap inside SHIFT, and SHALL be cleared on every accept.

Reset
REQ-025 Rst=1 SHALL force IDLE immediately, independent of Clk, in any state.
REQ-026 Reset values: shifter=0, count=0, Dout=0, Done=0, ShiftEn=0, SerOut=0, Ready=1.
REQ-027 A reset during SHIFT SHALL abort the transfer with no Done pulse and no Dout update.
REQ-028 Start SHALL be ignored while Rst=1 and on the edge where Rst is released.

Structure
REQ-029 The shared package SHALL hold the state typedef (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the default WIDTH constant.
REQ-030 The bit counter SHALL be a sub-module, shift_bit_counter, with clear, enable and terminal-count output.
REQ-031 The shifter, FSM and Dout register SHALL live in serial_shift_ctrl.

Verification
REQ-032 WIDTH=8, MSB_FIRST=1, SerIn looped to SerOut, Din=8'hA5 -> SerOut 1,0,1,0,0,1,0,1 and Done 9 cycles after accept with Dout=8'hA5.
REQ-033 Din=8'h00 with SerIn tied 1 -> SerOut all 0 for 8 cycles and Dout=8'hFF.
REQ-034 MSB_FIRST=0, loopback, Din=8'h01 -> SerOut 1 then seven 0s, and Dout=8'h01.
REQ-035 Start held high for 30 cycles -> accepts exactly every 10 cycles, Ready=0 throughout SHIFT/DONE, 3 Done pulses.
REQ-036 Rst pulsed after the 3rd SHIFT bit -> IDLE and Ready=1 immediately, no Done, Dout unchanged.
REQ-037 Start pulsed during the DONE cycle -> ignored; the next transfer begins only on a Start seen in IDLE.
